// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register for the MIPS32 datapath.
//
// Carries an opaque datapath bundle and a control bundle from one stage to the next.
// It can hold its contents (stall) or squash them into a bubble (flush). It also
// keeps two saturating event counters for the hazard unit and for debug.
//
// Parameters:
//   DATA_W   width of the datapath bundle (>= 1)
//   CTRL_W   width of the control bundle (>= 1)
//   CTRL_NOP control encoding that makes the stage architecturally inert
//   CNT_W    width of each event counter (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   stall      hold current contents this cycle
//   flush      replace current contents with a bubble this cycle (beats stall)
//   cnt_clr    synchronous clear of both event counters
//   in_valid   upstream stage holds a real instruction
//   in_data    upstream datapath bundle
//   in_ctrl    upstream control bundle
//   out_valid  registered valid
//   out_data   registered datapath bundle
//   out_ctrl   registered control bundle (CTRL_NOP whenever out_valid is 0)
//   stall_cnt  cycles spent holding a valid instruction (saturating)
//   flush_cnt  flushes that killed a valid instruction (saturating)
//
// Priority at each edge: rst > flush > stall > load. All outputs come straight
// from registers, so there is no combinational path from input to output.

module pipe_stage_reg #(
  parameter int unsigned              DATA_W   = 128,
  parameter int unsigned              CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]        CTRL_NOP = '0,
  parameter int unsigned              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic stall_evt;
  logic flush_evt;

  // Events are only counted when they affect a real instruction. A stalled or
  // flushed bubble costs nothing.
  assign stall_evt = stall & ~flush & valid_q;
  assign flush_evt = flush & valid_q;

  // Payload next-state.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      // Data is left alone: downstream ignores it once valid drops.
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else if (!stall) begin
      valid_d = in_valid;
      data_d  = in_data;
      // An invalid entry must never carry live control.
      ctrl_d  = in_valid ? in_ctrl : CTRL_NOP;
    end
  end

  // Counter next-state; clear beats any increment, and the counters stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      ctrl_q      <= CTRL_NOP;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg.
// For each cycle it computes the expected register contents from a behavioural model
// and pushes them onto a queue. After the edge it pops that entry and compares it
// with the DUT. It also makes directed checks with literal values for the
// scenarios listed in the test plan.

module tb_pipe_stage_reg;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 3;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [NW-1:0] sc;
    logic [NW-1:0] fc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          cnt_clr;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] flush_cnt;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t m;
  exp_t exp_q[$];

  pipe_stage_reg #(
    .DATA_W  (DW),
    .CTRL_W  (CW),
    .CTRL_NOP(8'h00),
    .CNT_W   (NW)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .cnt_clr  (cnt_clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one cycle of stimulus, predict the post-edge state, then compare it.
  task automatic step(input logic r, input logic s, input logic f, input logic cc,
                      input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic);
    exp_t e;
    exp_t got_e;
    rst      = r;
    stall    = s;
    flush    = f;
    cnt_clr  = cc;
    in_valid = iv;
    in_data  = id;
    in_ctrl  = ic;
    e = m;
    if (r) begin
      e.v  = 1'b0;
      e.d  = '0;
      e.c  = 8'h00;
      e.sc = '0;
      e.fc = '0;
    end else begin
      if (f) begin
        e.v = 1'b0;
        e.c = 8'h00;
      end else if (!s) begin
        e.v = iv;
        e.d = id;
        e.c = iv ? ic : 8'h00;
      end
      if (cc) begin
        e.sc = '0;
        e.fc = '0;
      end else begin
        if (s && !f && m.v && m.sc != 3'd7) e.sc = m.sc + 3'd1;
        if (f && m.v && m.fc != 3'd7) e.fc = m.fc + 3'd1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    check_eq("valid", 64'(out_valid), 64'(got_e.v));
    check_eq("data", 64'(out_data), 64'(got_e.d));
    check_eq("ctrl", 64'(out_ctrl), 64'(got_e.c));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(got_e.sc));
    check_eq("flush_cnt", 64'(flush_cnt), 64'(got_e.fc));
    check_eq("inv_nop", 64'(!out_valid && (out_ctrl != 8'h00)), 64'd0);
    m = got_e;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    m.v  = 1'b0;
    m.d  = '0;
    m.c  = 8'h00;
    m.sc = '0;
    m.fc = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b0; in_data = '0; in_ctrl = '0;

    // 1: reset with random inputs, then a load with latency 1
    repeat (2) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rnd64(),
                    8'($urandom));
    check_eq("t1_rst_valid", 64'(out_valid), 64'd0);
    check_eq("t1_rst_data", 64'(out_data), 64'd0);
    check_eq("t1_rst_ctrl", 64'(out_ctrl), 64'h00);
    check_eq("t1_rst_cnts", 64'({stall_cnt, flush_cnt}), 64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0123_4567_DEAD_BEEF, 8'h1D);
    check_eq("t1_load_valid", 64'(out_valid), 64'd1);
    check_eq("t1_load_data", 64'(out_data), 64'h0123_4567_DEAD_BEEF);
    check_eq("t1_load_ctrl", 64'(out_ctrl), 64'h1D);

    // 2: stall holds for N+1 cycles while inputs keep changing
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1234, 8'h05);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, rnd64(), 8'($urandom));
      check_eq("t2_hold_data", 64'(out_data), 64'h1234);
      check_eq("t2_hold_ctrl", 64'(out_ctrl), 64'h05);
    end
    check_eq("t2_stall_cnt", 64'(stall_cnt), 64'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hABCD, 8'h22);
    check_eq("t2_release_data", 64'(out_data), 64'hABCD);

    // 3: flush beats stall; flushing a bubble is not counted
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, rnd64(), 8'h7F);
    check_eq("t3_flush_valid", 64'(out_valid), 64'd0);
    check_eq("t3_flush_ctrl", 64'(out_ctrl), 64'h00);
    check_eq("t3_flush_cnt", 64'(flush_cnt), 64'd1);
    check_eq("t3_stall_cnt", 64'(stall_cnt), 64'd3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, rnd64(), 8'h7F);
    check_eq("t3_flush_cnt2", 64'(flush_cnt), 64'd1);

    // 4: invalid load never carries control, then a long random run
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd64(), 8'hFF);
    check_eq("t4_inv_valid", 64'(out_valid), 64'd0);
    check_eq("t4_inv_ctrl", 64'(out_ctrl), 64'h00);
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 3) != 0), rnd64(), 8'($urandom));
    end

    // 5: stall counter saturates at 7; clear beats a concurrent increment
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h5555, 8'h0C);
    check_eq("t5_clr", 64'({stall_cnt, flush_cnt}), 64'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rnd64(), 8'hFF);
    check_eq("t5_sat", 64'(stall_cnt), 64'd7);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, rnd64(), 8'hFF);
    check_eq("t5_clr_stall", 64'(stall_cnt), 64'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rnd64(), 8'hFF);
    check_eq("t5_after_clr", 64'(stall_cnt), 64'd1);
    check_eq("t5_held_data", 64'(out_data), 64'h5555);

    // 6: reset in the middle of a stall, then a normal load resumes
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h6666, 8'h31);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, rnd64(), 8'($urandom));
    check_eq("t6_stall_cnt", 64'(stall_cnt), 64'd5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rnd64(), 8'($urandom));
    check_eq("t6_rst_valid", 64'(out_valid), 64'd0);
    check_eq("t6_rst_data", 64'(out_data), 64'd0);
    check_eq("t6_rst_ctrl", 64'(out_ctrl), 64'h00);
    check_eq("t6_rst_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h7777_0000_BEEF, 8'h2A);
    check_eq("t6_load_data", 64'(out_data), 64'h7777_0000_BEEF);
    check_eq("t6_load_ctrl", 64'(out_ctrl), 64'h2A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the MIPS32 datapath; it replaces the fixed-field, always-loading inter-stage buffers such as IF/ID, ID/EX, EX/MEM and MEM/WB. It carries an opaque data bundle and a control bundle, with the following additions:
- synchronous reset
- stall (hold)
- flush (bubble insertion)
- a valid bit
- saturating stall and flush event counters for the hazard unit and debug.

One instance sits between each pair of pipeline stages.

Parameters:
DATA_W, 128, width of the datapath bundle (PC+4, ALU result, store data, branch target, dest reg, etc.); must be at least 1.
CTRL_W, 8, width of the control bundle (RegWrite, MemRead, MemWrite, MemToReg, Branch, Jump, ...); must be at least 1.
CTRL_NOP, {CTRL_W{1'b0}}, control value that makes the stage architecturally inert (no reg write, no mem access, no branch or jump).
CNT_W, 16, width of each event counter; must be at least 1.

Ports:
clk  in  1  rising-edge clock; the only clock.
rst  in  1  synchronous, active-high reset.
stall  in  1  hold current contents this cycle.
flush  in  1  replace current contents with a bubble this cycle.
cnt_clr  in  1  synchronous clear of both counters.
in_valid  in  1  upstream stage holds a real instruction.
in_data  in  DATA_W  upstream datapath bundle.
in_ctrl  in  CTRL_W  upstream control bundle.
out_valid  out  1  registered valid.
out_data  out  DATA_W  registered datapath bundle.
out_ctrl  out  CTRL_W  registered control bundle.
stall_cnt  out  CNT_W  count of cycles spent holding a valid instruction.
flush_cnt  out  CNT_W  count of flushes that killed a valid instruction.

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of clk only. Outputs are driven directly from registers; there is no combinational in->out path.
- Reset values when rst=1 at an edge: out_valid=0, out_data=0, out_ctrl=CTRL_NOP, stall_cnt=0, flush_cnt=0. Reset overrides every other input, including when asserted in the middle of a stall or flush sequence.
- Priority at each edge, highest first: rst > flush > stall > load.
  - flush=1: out_valid<=0 and out_ctrl<=CTRL_NOP. out_data holds its previous value (don't-care downstream). Flush wins over a simultaneous stall.
  - stall=1 and flush=0: out_valid, out_data and out_ctrl all hold.
  - Otherwise (load): out_valid<=in_valid and out_data<=in_data. out_ctrl<=in_ctrl when in_valid=1; out_ctrl<=CTRL_NOP when in_valid=0. An invalid entry therefore never carries live control.
- Latency: 1 cycle from input to output on a load. A stall of N cycles holds the output for N+1 consecutive cycles.
- Invariant: out_valid=0 implies out_ctrl==CTRL_NOP, in every cycle after reset.
- stall_cnt: increments by 1 on an edge where rst=0, cnt_clr=0, stall=1, flush=0 and out_valid=1 (the value before the edge). It saturates at 2^CNT_W-1 and does not wrap.
- flush_cnt: increments by 1 on an edge where rst=0, cnt_clr=0, flush=1 and out_valid=1 (the value before the edge). It saturates at all-ones. Flushing an already-invalid entry is not counted.
- Counter clear: cnt_clr=1 sets both counters to 0 and beats any increment in the same cycle. cnt_clr does not affect the data, control or valid registers.
- No X propagation: inputs are sampled only on a load edge. stall and flush are assumed to be known (non-X) whenever rst=0.

Test Plan:
1. Reset then load: rst=1 for 2 cycles with random inputs -> out_valid=0, out_data=0, out_ctrl=0, counters 0. Then release rst and drive in_valid=1, in_data=0x...DEAD_BEEF, in_ctrl=8'h1D -> exactly 1 cycle later out_valid=1, out_data=0x...DEAD_BEEF, out_ctrl=8'h1D.
2. Stall hold: load ctrl=8'h05 and data=0x1234, then stall=1 for 3 cycles while the inputs change every cycle -> outputs stay 0x1234/8'h05 for 4 cycles and stall_cnt=3. Deassert stall -> the new input appears on the next cycle.
3. Flush vs. stall: with a valid entry held, assert stall=1 and flush=1 together -> next cycle out_valid=0, out_ctrl=CTRL_NOP, flush_cnt=1, stall_cnt unchanged. Flush again while invalid -> flush_cnt stays 1.
4. Invalid load: in_valid=0 with in_ctrl=8'hFF -> out_valid=0 and out_ctrl=8'h00. Check the invariant on every cycle of a 10k-cycle random stall/flush/valid run against a reference model.
5. Saturation and clear: with CNT_W=3, hold a valid entry under stall for 10 cycles -> stall_cnt reaches 7 and stays at 7. Assert cnt_clr together with stall -> stall_cnt=0 on the next cycle, then 1 on the following stall cycle.
6. Reset mid-operation: during a stall with stall_cnt=5, assert rst for 1 cycle -> all outputs return to reset values on the next edge. After release, a normal load resumes with latency 1.
